// File: rtl/stripe_ctrl_pkg.sv
// Shared types and default sizing for the stripe scroll controller.
package stripe_ctrl_pkg;

  localparam int unsigned OFFSET_W_DEF = 10;
  localparam int unsigned LIMIT_DEF    = 1023;
  localparam int unsigned DEB_CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/frame_debounce.sv
// Two-flop synchroniser plus frame-rate debouncer for one button pin.
// The _c outputs give the level/edge decided at the current frame tick so the
// caller can act on it in that same cycle.
module frame_debounce
  import stripe_ctrl_pkg::*;
#(
  parameter int unsigned DEB_FRAMES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  input  logic tick_i,
  output logic level_c_o,
  output logic rise_c_o
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_FRAMES - 1);

  logic                 sync1_q, sync2_q;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 differs, accept;

  // Metastability synchroniser for the raw pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  assign differs = (sync2_q != level_q);
  assign accept  = tick_i && differs && (cnt_q == DEB_LAST);

  // Count consecutive tick samples disagreeing with the accepted level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick_i) begin
      if (!differs) begin
        cnt_d = '0;
      end else if (accept) begin
        cnt_d   = '0;
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DEB_CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_c_o = level_d;
  assign rise_c_o  = accept && sync2_q;

endmodule

// File: rtl/stripe_scroll_ctrl.sv
// Frame-synchronous scroll sequencer: debounced controls drive a small FSM
// and an offset/direction datapath that moves once per frame.
module stripe_scroll_ctrl
  import stripe_ctrl_pkg::*;
#(
  parameter int unsigned OFFSET_W   = OFFSET_W_DEF,
  parameter int unsigned LIMIT      = LIMIT_DEF,
  parameter int unsigned DEB_FRAMES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic                btn_run,
  input  logic                btn_step,
  input  logic                btn_dir,
  input  logic                btn_clr,
  input  logic                mode_bounce,
  input  logic [2:0]          speed,
  output logic [OFFSET_W-1:0] offset,
  output logic                dir,
  output logic [1:0]          state
);

  localparam int unsigned EXT_W = OFFSET_W + 1;

  logic [3:0] pin_vec, lvl_c, rise_c;
  logic       run_lvl, step_rise, dir_rise, clr_rise;
  logic       unused_lvl;

  logic       mode_s1_q, mode_s2_q;
  logic [2:0] speed_s1_q, speed_s2_q;

  state_e              state_q, state_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic                dir_q, dir_d;

  logic             move, clamp;
  logic [EXT_W-1:0] ext, inc, sum, diff;

  assign pin_vec = {btn_clr, btn_dir, btn_step, btn_run};

  // One debouncer per button: 0 run, 1 step, 2 dir, 3 clr.
  for (genvar g = 0; g < 4; g++) begin : g_deb
    frame_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .pin_i     (pin_vec[g]),
      .tick_i    (frame_tick),
      .level_c_o (lvl_c[g]),
      .rise_c_o  (rise_c[g])
    );
  end

  assign run_lvl    = lvl_c[0];
  assign step_rise  = rise_c[1];
  assign dir_rise   = rise_c[2];
  assign clr_rise   = rise_c[3];
  assign unused_lvl = ^{lvl_c[3:1], rise_c[0]};

  // Synchronise the undebounced level controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_q  <= 1'b0;
      mode_s2_q  <= 1'b0;
      speed_s1_q <= '0;
      speed_s2_q <= '0;
    end else begin
      mode_s1_q  <= mode_bounce;
      mode_s2_q  <= mode_s1_q;
      speed_s1_q <= speed;
      speed_s2_q <= speed_s1_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: clear beats run/pause, which beats step.
  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      if (clr_rise) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (run_lvl)        state_d = ST_RUN;
            else if (step_rise) state_d = ST_PAUSE;
          end
          ST_RUN:   if (!run_lvl) state_d = ST_PAUSE;
          ST_PAUSE: if (run_lvl)  state_d = ST_RUN;
          default:  state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Offset/dir update, decided from the pre-transition state.
  always_comb begin
    offset_d = offset_q;
    dir_d    = dir_q;
    move     = 1'b0;
    clamp    = 1'b0;
    inc      = '0;
    ext      = EXT_W'(offset_q);
    if (frame_tick && !clr_rise) begin
      case (state_q)
        ST_RUN: begin
          move = 1'b1;
          inc  = EXT_W'(speed_s2_q) + EXT_W'(1);
        end
        ST_IDLE, ST_PAUSE: begin
          if (!run_lvl && step_rise) begin
            move = 1'b1;
            inc  = EXT_W'(1);
          end
        end
        default: ;
      endcase
    end
    sum  = ext + inc;
    diff = ext - inc;
    if (frame_tick && clr_rise) begin
      offset_d = '0;
      dir_d    = 1'b1;
    end else begin
      if (move) begin
        if (mode_s2_q) begin
          if (dir_q) begin
            if (sum >= EXT_W'(LIMIT)) begin
              offset_d = OFFSET_W'(LIMIT);
              dir_d    = 1'b0;
              clamp    = 1'b1;
            end else begin
              offset_d = sum[OFFSET_W-1:0];
            end
          end else begin
            if (ext <= inc) begin
              offset_d = '0;
              dir_d    = 1'b1;
              clamp    = 1'b1;
            end else begin
              offset_d = diff[OFFSET_W-1:0];
            end
          end
        end else begin
          offset_d = dir_q ? sum[OFFSET_W-1:0] : diff[OFFSET_W-1:0];
        end
      end
      // A bounce clamp already fixed the direction; a same-tick toggle is dropped.
      if (dir_rise && !clamp) dir_d = ~dir_q;
    end
  end

  // Offset and direction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q <= '0;
      dir_q    <= 1'b1;
    end else begin
      offset_q <= offset_d;
      dir_q    <= dir_d;
    end
  end

  assign offset = offset_q;
  assign dir    = dir_q;
  assign state  = state_q;

endmodule

// File: tb/tb_stripe_scroll_ctrl.sv
// Directed bench for stripe_scroll_ctrl (OFFSET_W=10, LIMIT=100, DEB_FRAMES=2).
module tb_stripe_scroll_ctrl;

  localparam int unsigned IDLE  = 0;
  localparam int unsigned RUN   = 1;
  localparam int unsigned PAUSE = 2;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       btn_run, btn_step, btn_dir, btn_clr, mode_bounce;
  logic [2:0] speed;
  logic [9:0] offset;
  logic       dir;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  stripe_scroll_ctrl #(
    .OFFSET_W   (10),
    .LIMIT      (100),
    .DEB_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .btn_run     (btn_run),
    .btn_step    (btn_step),
    .btn_dir     (btn_dir),
    .btn_clr     (btn_clr),
    .mode_bounce (mode_bounce),
    .speed       (speed),
    .offset      (offset),
    .dir         (dir),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Let inputs settle through the synchronisers, pulse one tick, land on a negedge.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (3) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press_step();
    btn_step = 1'b1; ticks(2);
    btn_step = 1'b0; ticks(2);
  endtask

  task automatic press_dir();
    btn_dir = 1'b1; ticks(2);
    btn_dir = 1'b0; ticks(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0;
    btn_run = 1'b0; btn_step = 1'b0; btn_dir = 1'b0; btn_clr = 1'b0;
    mode_bounce = 1'b0; speed = 3'd0;
    repeat (3) @(negedge clk);
    check_val("rst_state", state, IDLE);
    check_val("rst_offset", offset, 0);
    check_val("rst_dir", dir, 1);
    rst_n = 1'b1;

    // Run at 4 px/frame: enters RUN on tick 2 without moving.
    btn_run = 1'b1; speed = 3'd3;
    ticks(1); check_val("run_t1_state", state, IDLE);
    ticks(1); check_val("run_t2_state", state, RUN);
              check_val("run_t2_offset", offset, 0);
    ticks(1); check_val("run_t3_offset", offset, 4);
    ticks(1); check_val("run_t4_offset", offset, 8);
    ticks(1); check_val("run_t5_offset", offset, 12);

    // Pause: last RUN tick still moves.
    btn_run = 1'b0;
    ticks(1); check_val("pause_t1_offset", offset, 16);
    ticks(1); check_val("pause_state", state, PAUSE);
              check_val("pause_offset", offset, 20);

    // Step held three frames advances exactly one pixel.
    btn_step = 1'b1; ticks(3);
    check_val("step_hold_offset", offset, 21);
    btn_step = 1'b0; ticks(2);
    check_val("step_rel_offset", offset, 21);

    // One-frame glitch is rejected.
    btn_step = 1'b1; ticks(1);
    btn_step = 1'b0; ticks(2);
    check_val("glitch_offset", offset, 21);
    check_val("glitch_state", state, PAUSE);

    // Clear returns to IDLE.
    btn_clr = 1'b1; ticks(2);
    check_val("clr_state", state, IDLE);
    check_val("clr_offset", offset, 0);
    check_val("clr_dir", dir, 1);
    btn_clr = 1'b0; ticks(2);

    // Three steps from IDLE: first enters PAUSE and applies.
    repeat (3) press_step();
    check_val("steps_offset", offset, 3);
    check_val("steps_state", state, PAUSE);
    press_dir();
    check_val("dir_toggle", dir, 0);
    check_val("dir_toggle_offset", offset, 3);

    // Wrap downward: 3 - 8 = 1019.
    speed = 3'd7; btn_run = 1'b1; ticks(2);
    check_val("wrapdn_state", state, RUN);
    check_val("wrapdn_hold", offset, 3);
    ticks(1); check_val("wrapdn_offset", offset, 1019);
    btn_run = 1'b0; ticks(2);
    check_val("wrapdn_pause", offset, 1003);
    check_val("wrapdn_pstate", state, PAUSE);
    press_dir();
    check_val("dir_back_up", dir, 1);

    // Wrap upward: 1016 + 8 = 0.
    speed = 3'd5; btn_run = 1'b1; ticks(2);
    ticks(1); check_val("wrapup_1009", offset, 1009);
    speed = 3'd6; ticks(1); check_val("wrapup_1016", offset, 1016);
    speed = 3'd7; ticks(1); check_val("wrapup_0", offset, 0);
    check_val("wrapup_dir", dir, 1);

    // Bounce at LIMIT=100.
    mode_bounce = 1'b1;
    ticks(12); check_val("bnc_96", offset, 96);
    ticks(1);  check_val("bnc_top_offset", offset, 100);
               check_val("bnc_top_dir", dir, 0);
    ticks(1);  check_val("bnc_92", offset, 92);
               check_val("bnc_92_dir", dir, 0);
    ticks(10); check_val("bnc_12", offset, 12);
    speed = 3'd6; ticks(1); check_val("bnc_5", offset, 5);
    speed = 3'd7; ticks(1); check_val("bnc_bot_offset", offset, 0);
                            check_val("bnc_bot_dir", dir, 1);

    // Dir edge on the clamp tick is dropped.
    ticks(11); check_val("clampdir_88", offset, 88);
    btn_dir = 1'b1; ticks(1); check_val("clampdir_96", offset, 96);
    ticks(1); check_val("clampdir_offset", offset, 100);
              check_val("clampdir_dir", dir, 0);
    btn_dir = 1'b0; ticks(2);
    check_val("clampdir_after", offset, 84);
    check_val("clampdir_after_dir", dir, 0);

    // Clear and step at the same tick in PAUSE: clear wins.
    btn_run = 1'b0; ticks(2);
    check_val("sim_pause_offset", offset, 68);
    check_val("sim_pause_state", state, PAUSE);
    btn_step = 1'b1; btn_clr = 1'b1; ticks(2);
    check_val("sim_state", state, IDLE);
    check_val("sim_offset", offset, 0);
    check_val("sim_dir", dir, 1);
    btn_step = 1'b0; btn_clr = 1'b0; ticks(2);

    // Async reset mid-RUN at offset 300.
    mode_bounce = 1'b0; speed = 3'd5; btn_run = 1'b1; ticks(2);
    ticks(50);
    check_val("prerst_offset", offset, 300);
    check_val("prerst_state", state, RUN);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; #1;
    check_val("midrst_offset", offset, 0);
    check_val("midrst_dir", dir, 1);
    check_val("midrst_state", state, IDLE);
    @(negedge clk); rst_n = 1'b1;
    ticks(1); check_val("postrst_t1_state", state, IDLE);
              check_val("postrst_t1_offset", offset, 0);
    ticks(1); check_val("postrst_t2_state", state, RUN);
              check_val("postrst_t2_offset", offset, 0);
    ticks(1); check_val("postrst_t3_offset", offset, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
